stk_ctrl: RTL

- Sequencing controller for a hardware stack held in an external single-port SRAM.
- Accepts PUSH/POP commands (stk_pkg::opcode_t) on a valid/ready channel and drives the SRAM.
- Tracks occupancy and returns exactly one response per command on a valid/ready response channel.
- Sits between a stack client and the SRAM macro; the SRAM is instantiated by the parent.

---
 rtl/stk_pkg.sv | 22 ++
 rtl/stk_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stk_pkg.sv
// Shared types for the SRAM-backed stack controller.
// Opcode and FSM state encodings plus an opcode legality helper.
package stk_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        RSP  = 2'b10
    } state_t;

    function automatic logic is_legal_opcode(input opcode_t op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/stk_ctrl.sv
// Stack sequencer: PUSH/POP commands in, SRAM accesses out,
// one registered response per command.
module stk_ctrl
    import stk_pkg::*;
#(
    parameter int N  = 16,
    parameter int W  = 32,
    parameter int AW = $clog2(N),
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          cmd_vld,
    input  opcode_t       cmd_opcode,
    input  logic [W-1:0]  cmd_dat,
    output logic          cmd_rdy,
    output logic          rsp_vld,
    output logic [W-1:0]  rsp_dat,
    output logic          rsp_err,
    input  logic          rsp_rdy,
    output logic          sram_en,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [W-1:0]  sram_wdat,
    input  logic [W-1:0]  sram_rdat,
    output logic [CW-1:0] sts_cnt,
    output logic          sts_full,
    output logic          sts_empty
);

    localparam logic [CW-1:0] LP_N = CW'(N);

    state_t        r_state;
    state_t        w_nstate;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_m1;
    logic [W-1:0]  r_rsp_dat;
    logic [W-1:0]  w_rsp_dat_nxt;
    logic          r_rsp_err;
    logic          w_rsp_err_nxt;
    logic          w_rsp_ld;
    logic          w_acc;
    logic          w_full;
    logic          w_empty;
    logic          w_legal;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_full    = (r_cnt == LP_N);
    assign w_empty   = (r_cnt == '0);
    assign w_cnt_m1  = r_cnt - CW'(1);
    assign w_legal   = is_legal_opcode(cmd_opcode);

    assign cmd_rdy   = (r_state == IDLE) |
                       ((r_state == RSP) & rsp_rdy);
    assign w_acc     = cmd_vld & cmd_rdy;
    assign w_push_ok = w_acc & w_legal &
                       (cmd_opcode == OP_PUSH) & ~w_full;
    assign w_pop_ok  = w_acc & w_legal &
                       (cmd_opcode == OP_POP) & ~w_empty;

    always_comb begin
        w_nstate      = r_state;
        w_cnt_nxt     = r_cnt;
        w_rsp_ld      = 1'b0;
        w_rsp_dat_nxt = r_rsp_dat;
        w_rsp_err_nxt = r_rsp_err;
        sram_en       = 1'b0;
        sram_wen      = 1'b0;
        sram_addr     = '0;
        sram_wdat     = '0;

        unique case (r_state)
            RD: begin
                w_nstate      = RSP;
                w_rsp_ld      = 1'b1;
                w_rsp_dat_nxt = sram_rdat;
                w_rsp_err_nxt = 1'b0;
            end
            RSP: begin
                if (rsp_rdy) w_nstate = IDLE;
            end
            default: ;
        endcase

        // An accepted command overrides the RSP->IDLE drain above.
        if (w_acc) begin
            w_nstate      = RSP;
            w_rsp_ld      = 1'b1;
            w_rsp_dat_nxt = '0;
            w_rsp_err_nxt = 1'b1;
            unique case (1'b1)
                w_push_ok: begin
                    sram_en       = 1'b1;
                    sram_wen      = 1'b1;
                    sram_addr     = AW'(r_cnt);
                    sram_wdat     = cmd_dat;
                    w_cnt_nxt     = r_cnt + CW'(1);
                    w_rsp_err_nxt = 1'b0;
                end
                w_pop_ok: begin
                    sram_en   = 1'b1;
                    sram_addr = AW'(w_cnt_m1);
                    w_cnt_nxt = w_cnt_m1;
                    w_nstate  = RD;
                    w_rsp_ld  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt_nxt;
            if (w_rsp_ld) begin
                r_rsp_dat <= w_rsp_dat_nxt;
                r_rsp_err <= w_rsp_err_nxt;
            end
        end
    end

    assign rsp_vld   = (r_state == RSP);
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign sts_cnt   = r_cnt;
    assign sts_full  = w_full;
    assign sts_empty = w_empty;

endmodule
